// File: rtl/spi_pkg.sv
// Shared types and constants for the SD-card command SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_R1,
    RECV_R1,
    RECV_DATA,
    FINISH
  } state_t;

  localparam int CMD_BITS  = 48;
  localparam int DATA_BITS = 32;

  // spi_statusreg_i bit positions
  localparam int GO   = 0;
  localparam int RX32 = 2;

  // spi_flagreg_o bit positions
  localparam int BUSY    = 0;
  localparam int DONE    = 1;
  localparam int TIMEOUT = 2;

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: low for the first half of each bit-time, high for the second.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic spi_clk_i,
  input  logic spi_rst_i,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i || !en) begin
      cnt <= '0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Strobes flag the cycle before the edge on which SCK rises or falls.
  assign sck  = (cnt >= CW'(HALF));
  assign rise = en && (cnt == CW'(HALF - 1));
  assign fall = en && (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/spi.sv
// SPI master: sends one 48-bit SD command frame, waits for R1, optionally reads a 32-bit word.
module spi
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NCR_MAX = 8
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic [47:0] spi_data_i,
  input  logic [7:0]  spi_statusreg_i,
  input  logic        MISO,
  output logic        MOSI,
  output logic        SCK_SPI,
  output logic        SS,
  output logic [7:0]  R1,
  output logic [31:0] spi_data_o,
  output logic [2:0]  spi_flagreg_o
);

  localparam int WAIT_BITS = NCR_MAX * 8;
  localparam int CNT_W     = $clog2(((WAIT_BITS > CMD_BITS) ? WAIT_BITS : CMD_BITS) + 1);

  state_t               state_q, state_d;
  logic                 go, go_q, rx32_q, timeout_q;
  logic [CMD_BITS-1:0]  tx_sr;
  logic [DATA_BITS-1:0] rx_sr, data_q;
  logic [7:0]           r1_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 sck_en, sck, sck_rise, sck_fall;
  logic                 unused_status;

  assign go            = spi_statusreg_i[GO];
  assign unused_status = ^{spi_statusreg_i[7:3], spi_statusreg_i[1]};

  assign sck_en = (state_q != IDLE) && (state_q != FINISH);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .spi_clk_i (spi_clk_i),
    .spi_rst_i (spi_rst_i),
    .en        (sck_en),
    .sck       (sck),
    .rise      (sck_rise),
    .fall      (sck_fall)
  );

  // Start uses the registered request so SS falls one edge after GO is sampled;
  // release from FINISH follows GO directly.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:      if (go_q) state_d = SEND;
      SEND:      if (sck_fall && bit_cnt == CNT_W'(CMD_BITS - 1)) state_d = WAIT_R1;
      WAIT_R1: begin
        if (sck_rise && !MISO) state_d = RECV_R1;
        else if (sck_fall && bit_cnt == CNT_W'(WAIT_BITS)) state_d = FINISH;
      end
      RECV_R1:   if (sck_fall && bit_cnt == CNT_W'(8)) state_d = rx32_q ? RECV_DATA : FINISH;
      RECV_DATA: if (sck_fall && bit_cnt == CNT_W'(DATA_BITS)) state_d = FINISH;
      FINISH:    if (!go) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      state_q   <= IDLE;
      go_q      <= 1'b0;
      rx32_q    <= 1'b0;
      timeout_q <= 1'b0;
      tx_sr     <= '1;
      rx_sr     <= '0;
      data_q    <= '0;
      r1_q      <= 8'hFF;
      bit_cnt   <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
      case (state_q)
        IDLE: begin
          if (go_q) begin
            tx_sr     <= spi_data_i;
            rx32_q    <= spi_statusreg_i[RX32];
            timeout_q <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        SEND: begin
          // Ones shift in behind the frame, so MOSI is already high for the receive phases.
          if (sck_fall) begin
            tx_sr   <= {tx_sr[CMD_BITS-2:0], 1'b1};
            bit_cnt <= (bit_cnt == CNT_W'(CMD_BITS - 1)) ? '0 : bit_cnt + 1'b1;
          end
        end
        WAIT_R1: begin
          if (sck_rise) begin
            if (!MISO) begin
              rx_sr   <= {rx_sr[DATA_BITS-2:0], 1'b0};
              bit_cnt <= CNT_W'(1);
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall && bit_cnt == CNT_W'(WAIT_BITS)) begin
            r1_q      <= 8'hFF;
            timeout_q <= 1'b1;
          end
        end
        RECV_R1: begin
          if (sck_rise) begin
            rx_sr   <= {rx_sr[DATA_BITS-2:0], MISO};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(7)) r1_q <= {rx_sr[6:0], MISO};
          end else if (sck_fall && bit_cnt == CNT_W'(8)) begin
            bit_cnt <= '0;
          end
        end
        RECV_DATA: begin
          if (sck_rise) begin
            rx_sr   <= {rx_sr[DATA_BITS-2:0], MISO};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_BITS - 1)) data_q <= {rx_sr[DATA_BITS-2:0], MISO};
          end
        end
        FINISH: begin
          if (!go) timeout_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign MOSI       = tx_sr[CMD_BITS-1];
  assign SCK_SPI    = sck;
  assign SS         = !sck_en;
  assign R1         = r1_q;
  assign spi_data_o = data_q;

  always_comb begin
    spi_flagreg_o          = '0;
    spi_flagreg_o[BUSY]    = sck_en;
    spi_flagreg_o[DONE]    = (state_q == FINISH);
    spi_flagreg_o[TIMEOUT] = timeout_q;
  end

endmodule

// File: tb/tb_spi.sv
// Self-checking bench for spi: directed vector table, reset corner cases, randomized card responses.
module tb_spi;

  localparam int CLK_DIV   = 4;
  localparam int NCR_MAX   = 8;
  localparam int WAIT_BITS = NCR_MAX * 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] data_i = '0;
  logic [7:0]  status = '0;
  logic        miso;
  logic        mosi, sck, ss;
  logic [7:0]  r1;
  logic [31:0] data_o;
  logic [2:0]  flags;

  spi #(.CLK_DIV(CLK_DIV), .NCR_MAX(NCR_MAX)) dut (
    .spi_clk_i       (clk),
    .spi_rst_i       (rst),
    .spi_data_i      (data_i),
    .spi_statusreg_i (status),
    .MISO            (miso),
    .MOSI            (mosi),
    .SCK_SPI         (sck),
    .SS              (ss),
    .R1              (r1),
    .spi_data_o      (data_o),
    .spi_flagreg_o   (flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [47:0] frame;
    logic [7:0]  status;
    int          lead;       // filler bytes the card sends before R1
    logic [7:0]  card_r1;
    logic [31:0] card_word;
    bit          drop;       // release GO mid-transaction
    logic [7:0]  exp_r1;
    logic [31:0] exp_data;
    logic [2:0]  exp_flags;
    int          exp_bits;
  } vec_t;

  // Card: response stream indexed by bit-time since SS fell; changes after each SCK fall.
  int          card_lead = 0;
  logic [7:0]  card_r1   = 8'hFF;
  logic [31:0] card_word = '0;

  function automatic logic stream_bit(input int k);
    int j;
    if (k < 48) return 1'b1;
    j = k - 48 - 8 * card_lead;
    if (j < 0)  return 1'b1;
    if (j < 8)  return card_r1[7-j];
    if (j < 40) return card_word[39-j];
    return 1'b1;
  endfunction

  initial begin : card
    int k;
    miso = 1'b1;
    forever begin
      @(negedge ss);
      k = 0;
      miso = stream_bit(k);
      while (ss === 1'b0) begin
        @(negedge sck or posedge ss);
        if (ss !== 1'b0) break;
        k++;
        miso = stream_bit(k);
      end
      miso = 1'b1;
    end
  end

  bit cap_q[$];
  always @(posedge sck) if (ss === 1'b0) cap_q.push_back(mosi);

  // Reference model: outcome derived from the card's response timing.
  logic [7:0]  prev_r1   = 8'hFF;
  logic [31:0] prev_data = '0;

  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    if (v.lead >= NCR_MAX) begin
      o.exp_r1    = 8'hFF;
      o.exp_data  = prev_data;
      o.exp_flags = 3'b110;
      o.exp_bits  = 48 + WAIT_BITS;
    end else begin
      o.exp_r1    = v.card_r1;
      o.exp_data  = v.status[2] ? v.card_word : prev_data;
      o.exp_flags = 3'b010;
      o.exp_bits  = 48 + 8 * v.lead + 8 + (v.status[2] ? 32 : 0);
    end
    return o;
  endfunction

  task automatic run_txn(input vec_t v);
    int          cyc;
    logic [47:0] got_frame;
    bit          fill_ok, seen_low;
    card_lead = v.lead;
    card_r1   = v.card_r1;
    card_word = v.card_word;
    data_i    = v.frame;
    cap_q.delete();
    @(negedge clk);
    status = v.status;
    @(negedge clk);
    check("start_ss_wait", ss, 1'b1);
    @(negedge clk);
    check("start_ss", ss, 1'b0);
    check("start_mosi", mosi, v.frame[47]);
    check("busy", flags, 3'b001);
    cyc = 0;
    while (ss !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (v.drop && cyc == 40) status[0] = 1'b0;
    end
    check("duration", cyc, v.exp_bits * CLK_DIV);
    check("flags_end", flags, v.exp_flags);
    check("r1", r1, v.exp_r1);
    check("data", data_o, v.exp_data);
    check("sck_count", cap_q.size(), v.exp_bits);
    got_frame = '0;
    fill_ok   = 1'b1;
    foreach (cap_q[i]) begin
      if (i < 48) got_frame = {got_frame[46:0], cap_q[i]};
      else if (!cap_q[i]) fill_ok = 1'b0;
    end
    check("mosi_frame", got_frame, v.frame);
    check("mosi_fill", fill_ok, 1'b1);
    if (!v.drop) begin
      seen_low = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (ss !== 1'b1) seen_low = 1'b1;
      end
      check("no_restart", seen_low, 1'b0);
      check("hold_flags", flags, v.exp_flags);
      status[0] = 1'b0;
    end
    @(negedge clk);
    check("idle_flags", flags, 3'b000);
    check("idle_mosi_sck", {mosi, sck}, 2'b10);
    status    = '0;
    prev_r1   = v.exp_r1;
    prev_data = v.exp_data;
  endtask

  vec_t tbl [6];
  vec_t v;
  logic [63:0] rnd;

  initial begin
    tbl[0] = '{48'h56781234ABCD, 8'h45, 8, 8'h00, 32'h0,          1'b0, 8'hFF, 32'h0,          3'b110, 112};
    tbl[1] = '{48'h48000001AA87, 8'h45, 2, 8'h01, 32'h000001AA,   1'b0, 8'h01, 32'h000001AA,   3'b010, 104};
    tbl[2] = '{48'h400000000095, 8'h41, 0, 8'h01, 32'h12345678,   1'b0, 8'h01, 32'h000001AA,   3'b010, 56};
    tbl[3] = '{48'h7A00000000FD, 8'hFD, 0, 8'h00, 32'hDEADBEEF,   1'b1, 8'h00, 32'hDEADBEEF,   3'b010, 88};
    tbl[4] = '{48'hFFFFFFFFFFFF, 8'h41, 7, 8'h7F, 32'h0,          1'b0, 8'h7F, 32'hDEADBEEF,   3'b010, 112};
    tbl[5] = '{48'h000000000001, 8'h45, 9, 8'h01, 32'h55AA55AA,   1'b1, 8'hFF, 32'hDEADBEEF,   3'b110, 112};

    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_ss", ss, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b1);
    check("rst_r1", r1, 8'hFF);
    check("rst_data", data_o, 32'h0);
    check("rst_flags", flags, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Reset in the middle of SEND, then a fresh transaction must start again at bit 47.
    card_lead = 0;
    data_i    = 48'hA5A50F0F3C3C;
    status    = 8'h01;
    repeat (62) @(negedge clk);
    check("mid_send_ss", ss, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ss", ss, 1'b1);
    check("mid_rst_sck", sck, 1'b0);
    check("mid_rst_mosi", mosi, 1'b1);
    check("mid_rst_r1", r1, 8'hFF);
    check("mid_rst_data", data_o, 32'h0);
    check("mid_rst_flags", flags, 3'b000);
    rst       = 1'b0;
    status    = '0;
    prev_r1   = 8'hFF;
    prev_data = '0;
    repeat (3) @(negedge clk);
    v = '{48'hA5A50F0F3C3C, 8'h45, 1, 8'h01, 32'h12345678, 1'b0, 8'h0, 32'h0, 3'b0, 0};
    run_txn(model(v));

    for (int i = 0; i < 8; i++) begin
      rnd         = {$urandom, $urandom};
      v.frame     = rnd[47:0];
      v.status    = 8'($urandom) | 8'h01;
      v.lead      = $urandom_range(0, NCR_MAX + 1);
      v.card_r1   = {1'b0, 7'($urandom)};
      v.card_word = $urandom;
      v.drop      = 1'($urandom_range(0, 1));
      run_txn(model(v));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
